reg_share_arbiter: RTL and testbench

REG_SHARE_ARBITER -- requirements
Module: reg_share_arbiter

---
 rtl/reg_share_arbiter_if.sv | 27 ++
 rtl/reg_share_arbiter.sv | 110 +++++++++++
 tb/tb_reg_share_arbiter.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_share_arbiter_if.sv
// Request/data/grant bundle between requesters and the shared-register arbiter.
// The master side drives requests and write data; the slave side returns grants, acks and the load port.
interface reg_share_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int N_REQ = 3
);
  logic [N_REQ-1:0] req;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [N_REQ-1:0] gnt;
  logic             ld;
  logic [WIDTH-1:0] d_out;
  logic [N_REQ-1:0] ack;
  logic             busy;
  logic [7:0]       load_cnt;

  modport master (
    output req, d0, d1, d2,
    input  gnt, ld, d_out, ack, busy, load_cnt
  );

  modport slave (
    input  req, d0, d1, d2,
    output gnt, ld, d_out, ack, busy, load_cnt
  );
endinterface

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter sharing one parallel-load register among three writers; falling-edge state.
// Load 1 cycle after a request from IDLE; one load per 2 cycles back to back; requesters hold req until ack.
module reg_share_arbiter #(
  parameter int WIDTH = 4,
  parameter int N_REQ = 3
) (
  input logic                clock,
  input logic                reset_n,
  reg_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;

  state_t           state_q, state_d;
  logic [1:0]       win_q, win_d;
  logic [1:0]       last_q, last_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             ld_q, ld_d;
  logic [WIDTH-1:0] d_out_q, d_out_d;
  logic [7:0]       cnt_q, cnt_d;

  logic             pick_vld;
  logic [1:0]       pick_idx;
  logic [1:0]       cand;
  logic [WIDTH-1:0] pick_dat;

  // Search starts one past the last winner and wraps, so a waiting requester sees at most two others first.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = last_q;
    cand     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = 2'((int'(last_q) + k) % N_REQ);
      if (!pick_vld && bus.req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    case (pick_idx)
      2'd0:    pick_dat = bus.d0;
      2'd1:    pick_dat = bus.d1;
      default: pick_dat = bus.d2;
    endcase
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    gnt_d   = '0;
    ack_d   = '0;
    ld_d    = 1'b0;
    d_out_d = d_out_q;
    cnt_d   = cnt_q;
    case (state_q)
      GRANT: begin
        // The load is committed once granted; a dropped req here does not cancel it.
        state_d       = ACK;
        ack_d[win_q]  = 1'b1;
        last_d        = win_q;
        cnt_d         = cnt_q + 8'd1;
      end
      default: begin
        if (pick_vld) begin
          state_d         = GRANT;
          win_d           = pick_idx;
          gnt_d[pick_idx] = 1'b1;
          ld_d            = 1'b1;
          d_out_d         = pick_dat;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(negedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      win_q   <= 2'd0;
      last_q  <= 2'd2;
      gnt_q   <= '0;
      ack_q   <= '0;
      ld_q    <= 1'b0;
      d_out_q <= '0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      ld_q    <= ld_d;
      d_out_q <= d_out_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.ack      = ack_q;
  assign bus.ld       = ld_q;
  assign bus.d_out    = d_out_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.load_cnt = cnt_q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Bench for reg_share_arbiter: directed scenarios plus randomized requesters against a transaction-level model.
module tb_reg_share_arbiter;

  logic clock;
  logic reset_n;

  reg_share_arbiter_if #(.WIDTH(4), .N_REQ(3)) bus ();

  reg_share_arbiter #(.WIDTH(4), .N_REQ(3)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clock = 1'b1;
    forever #5 clock = ~clock;
  end

  int errors = 0;
  int checks = 0;

  // Model: phase 0 = no transfer, 1 = register being loaded, 2 = completion pulse.
  int         m_phase = 0;
  int         m_win   = 0;
  int         m_last  = 2;
  int         m_cnt   = 0;
  logic [3:0] m_dout  = 4'h0;

  function automatic int rr_pick(logic [2:0] r, int last);
    for (int k = 1; k <= 3; k++) begin
      if (r[(last + k) % 3]) return (last + k) % 3;
    end
    return -1;
  endfunction

  function automatic logic [19:0] model_vec();
    logic [2:0] g;
    logic [2:0] a;
    g = (m_phase == 1) ? 3'(1 << m_win) : 3'b000;
    a = (m_phase == 2) ? 3'(1 << m_win) : 3'b000;
    return {g, (m_phase == 1), a, (m_phase != 0), m_dout, 8'(m_cnt)};
  endfunction

  function automatic logic [19:0] dut_vec();
    return {bus.gnt, bus.ld, bus.ack, bus.busy, bus.d_out, bus.load_cnt};
  endfunction

  // Advances one falling edge; the model consumes exactly the inputs the DUT sampled.
  task automatic step();
    logic       rn;
    logic [2:0] r;
    logic [3:0] d [3];
    int         p;
    rn   = reset_n;
    r    = bus.req;
    d[0] = bus.d0;
    d[1] = bus.d1;
    d[2] = bus.d2;
    @(negedge clock);
    #1;
    if (!rn) begin
      m_phase = 0;
      m_last  = 2;
      m_cnt   = 0;
      m_dout  = 4'h0;
    end else if (m_phase == 1) begin
      m_phase = 2;
      m_last  = m_win;
      m_cnt   = (m_cnt + 1) % 256;
    end else begin
      p = rr_pick(r, m_last);
      if (p >= 0) begin
        m_phase = 1;
        m_win   = p;
        m_dout  = d[p];
      end else begin
        m_phase = 0;
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.req = 3'($urandom);
    bus.d0  = 4'($urandom);
    bus.d1  = 4'($urandom);
    bus.d2  = 4'($urandom);
    step();
    step();
    reset_n = 1'b1;
    bus.req = 3'b000;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dut_vec() !== 20'h0) begin
      errors++;
      $display("FAIL reset_state: got %h, want 00000", dut_vec());
    end
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.gnt !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle_stays: busy=%b gnt=%b, want 0 000", bus.busy, bus.gnt);
    end
  endtask

  task automatic test_single_load();
    do_reset();
    bus.req = 3'b001;
    bus.d0  = 4'hA;
    step();
    checks++;
    if (bus.gnt !== 3'b001 || bus.ld !== 1'b1 || bus.d_out !== 4'hA || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: gnt=%b ld=%b d_out=%h busy=%b, want 001 1 a 1",
               bus.gnt, bus.ld, bus.d_out, bus.busy);
    end
    step();
    bus.req = 3'b000;
    checks++;
    if (bus.ack !== 3'b001 || bus.load_cnt !== 8'd1 || bus.ld !== 1'b0 || bus.gnt !== 3'b000
        || bus.d_out !== 4'hA) begin
      errors++;
      $display("FAIL single_ack: ack=%b cnt=%0d ld=%b gnt=%b d_out=%h, want 001 1 0 000 a",
               bus.ack, bus.load_cnt, bus.ld, bus.gnt, bus.d_out);
    end
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.ack !== 3'b000 || bus.d_out !== 4'hA) begin
      errors++;
      $display("FAIL single_idle: busy=%b ack=%b d_out=%h, want 0 000 a", bus.busy, bus.ack, bus.d_out);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g [8];
    exp_g = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000};
    do_reset();
    bus.req = 3'b111;
    bus.d0  = 4'h1;
    bus.d1  = 4'h2;
    bus.d2  = 4'h3;
    for (int n = 0; n < 8; n++) begin
      step();
      checks++;
      if (bus.gnt !== exp_g[n] || bus.ld !== (exp_g[n] != 3'b000)) begin
        errors++;
        $display("FAIL rr_all_grant[%0d]: gnt=%b ld=%b, want %b", n, bus.gnt, bus.ld, exp_g[n]);
      end
    end
    checks++;
    if (bus.ack !== 3'b001 || bus.load_cnt !== 8'd4) begin
      errors++;
      $display("FAIL rr_all_count: ack=%b cnt=%0d, want 001 4", bus.ack, bus.load_cnt);
    end
    bus.req = 3'b000;
    step();
  endtask

  task automatic test_skip();
    logic [2:0] exp_g [4];
    exp_g = '{3'b000, 3'b100, 3'b000, 3'b001};
    do_reset();
    bus.req = 3'b001;
    step();
    bus.req = 3'b101;
    for (int n = 0; n < 4; n++) begin
      step();
      checks++;
      if (bus.gnt !== exp_g[n]) begin
        errors++;
        $display("FAIL rr_skip[%0d]: gnt=%b, want %b", n, bus.gnt, exp_g[n]);
      end
    end
    bus.req = 3'b000;
    step();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    bus.req = 3'b010;
    bus.d1  = 4'h7;
    step();
    reset_n = 1'b0;
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.ack !== 3'b000 || bus.load_cnt !== 8'd0 || bus.ld !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_grant: busy=%b ack=%b cnt=%0d ld=%b, want 0 000 0 0",
               bus.busy, bus.ack, bus.load_cnt, bus.ld);
    end
    reset_n = 1'b1;
    bus.req = 3'b000;
    step();
    checks++;
    if (bus.ack !== 3'b000 || bus.load_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_no_late_ack: ack=%b cnt=%0d, want 000 0", bus.ack, bus.load_cnt);
    end
  endtask

  task automatic test_drop_during_grant();
    do_reset();
    bus.req = 3'b010;
    bus.d1  = 4'h5;
    step();
    checks++;
    if (bus.gnt !== 3'b010 || bus.d_out !== 4'h5) begin
      errors++;
      $display("FAIL drop_grant: gnt=%b d_out=%h, want 010 5", bus.gnt, bus.d_out);
    end
    bus.req = 3'b000;
    step();
    checks++;
    if (bus.ack !== 3'b010 || bus.load_cnt !== 8'd1 || bus.d_out !== 4'h5) begin
      errors++;
      $display("FAIL drop_ack: ack=%b cnt=%0d d_out=%h, want 010 1 5", bus.ack, bus.load_cnt, bus.d_out);
    end
    step();
  endtask

  task automatic test_wrap();
    do_reset();
    bus.req = 3'b001;
    for (int l = 1; l <= 256; l++) begin
      bus.d0 = 4'($urandom);
      step();
      step();
      if (l == 255) begin
        checks++;
        if (bus.load_cnt !== 8'd255) begin
          errors++;
          $display("FAIL wrap_255: cnt=%0d, want 255", bus.load_cnt);
        end
      end
    end
    checks++;
    if (bus.load_cnt !== 8'd0 || bus.ack !== 3'b001) begin
      errors++;
      $display("FAIL wrap_zero: cnt=%0d ack=%b, want 0 001", bus.load_cnt, bus.ack);
    end
    bus.req = 3'b000;
    step();
  endtask

  task automatic test_random();
    logic [2:0] pend;
    logic [3:0] dat [3];
    pend = 3'b000;
    dat  = '{4'h0, 4'h0, 4'h0};
    do_reset();
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] && $urandom_range(2) == 0) begin
          pend[i] = 1'b1;
          dat[i]  = 4'($urandom);
        end
      end
      reset_n = ($urandom_range(60) != 0);
      bus.req = pend;
      bus.d0  = dat[0];
      bus.d1  = dat[1];
      bus.d2  = dat[2];
      step();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL random[%0d]: got %h, want %h", n, dut_vec(), model_vec());
      end
      if (m_phase == 2) begin
        pend[m_win] = ($urandom_range(3) == 0);
        dat[m_win]  = 4'($urandom);
      end
    end
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    bus.req = 3'b000;
    bus.d0  = 4'h0;
    bus.d1  = 4'h0;
    bus.d2  = 4'h0;
    test_reset();
    test_single_load();
    test_round_robin();
    test_skip();
    test_reset_mid_grant();
    test_drop_during_grant();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
